// File: rtl/sdram_host_arb_pkg.sv
// sdram_host_arb_pkg: shared state encodings and constants for the host port arbiter
package sdram_host_arb_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;
  localparam logic ARB_PA = 1'b0;
  localparam logic ARB_PB = 1'b1;
  localparam logic [15:0] TMO_RDAT = 16'hFFFF;
endpackage

// File: rtl/sdram_host_arb_wdog.sv
// sdram_host_arb_wdog: clearable up-counter flagging the last allowed ISSUE cycle
module sdram_host_arb_wdog #(
  parameter int TMO = 255,
  localparam int W = $clog2(TMO + 1)
) (
  input  logic clk,
  input  logic _rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [W-1:0] cnt_q, cnt_d;
  // cnt_q holds (ISSUE cycle number - 1), so tc marks the TMO-th cycle; holding at tc avoids wrap
  always_comb begin
    tc = cnt_q == W'(TMO - 1);
    cnt_d = clr ? '0 : (en && !tc) ? cnt_q + 1'b1 : cnt_q;
  end
  // counter register
  always_ff @(posedge clk or negedge _rst)
    if (!_rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/sdram_host_arb.sv
// sdram_host_arb: round-robin sharing of the sdram_ctrl host port between two requesters
module sdram_host_arb
  import sdram_host_arb_pkg::*;
#(
  parameter int AW  = 22,
  parameter int TMO = 255
) (
  input  logic          clk,
  input  logic          _rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:1] a_adr,
  input  logic [1:0]    a_bs,
  input  logic [15:0]   a_wdat,
  output logic [15:0]   a_rdat,
  output logic          a_ack,
  output logic          a_err,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:1] b_adr,
  input  logic [1:0]    b_bs,
  input  logic [15:0]   b_wdat,
  output logic [15:0]   b_rdat,
  output logic          b_ack,
  output logic          b_err,
  output logic          host_cs,
  output logic [AW-1:0] host_adr,
  output logic          host_we,
  output logic [1:0]    host_bs,
  output logic [15:0]   host_wdat,
  input  logic [15:0]   host_rdat,
  input  logic          host_ack,
  output logic          tmo_flag
);
  arb_state_t    state_q, state_d;
  logic          last_q, last_d, gnt_q, gnt_d, we_q, we_d;
  logic [AW-1:1] adr_q, adr_d;
  logic [1:0]    bs_q, bs_d;
  logic [15:0]   wdat_q, wdat_d, a_rdat_q, a_rdat_d, b_rdat_q, b_rdat_d, nrd;
  logic          a_ack_q, a_ack_d, b_ack_q, b_ack_d, a_err_q, a_err_d, b_err_q, b_err_d;
  logic          tmo_q, tmo_d, pick, grant, done, upd, wd_tc;

  sdram_host_arb_wdog #(.TMO(TMO)) u_wdog (
    .clk(clk), ._rst(_rst), .clr(grant), .en(state_q == ARB_ISSUE), .tc(wd_tc)
  );

  // grant selection, latching of the winner, completion/abort and result routing
  always_comb begin
    pick     = (a_req && b_req) ? ~last_q : b_req;
    grant    = state_q == ARB_IDLE && (a_req || b_req);
    done     = state_q == ARB_ISSUE && (host_ack || wd_tc);
    nrd      = host_ack ? host_rdat : TMO_RDAT;
    upd      = done && !(host_ack && we_q);
    state_d  = grant ? ARB_ISSUE : done ? ARB_RELEASE : state_q == ARB_RELEASE ? ARB_IDLE : state_q;
    last_d   = grant ? pick : last_q;
    gnt_d    = grant ? pick : gnt_q;
    we_d     = grant ? (pick ? b_we : a_we) : we_q;
    adr_d    = grant ? (pick ? b_adr : a_adr) : adr_q;
    bs_d     = grant ? (pick ? b_bs : a_bs) : bs_q;
    wdat_d   = grant ? (pick ? b_wdat : a_wdat) : wdat_q;
    a_rdat_d = (upd && gnt_q == ARB_PA) ? nrd : a_rdat_q;
    b_rdat_d = (upd && gnt_q == ARB_PB) ? nrd : b_rdat_q;
    a_ack_d  = done && gnt_q == ARB_PA;
    b_ack_d  = done && gnt_q == ARB_PB;
    a_err_d  = a_ack_d && !host_ack;
    b_err_d  = b_ack_d && !host_ack;
    tmo_d    = tmo_q || (done && !host_ack);
  end

  // state registers; last starts at B so A wins the first tie
  always_ff @(posedge clk or negedge _rst)
    if (!_rst) begin
      state_q  <= ARB_IDLE;
      last_q   <= ARB_PB;
      gnt_q    <= ARB_PA;
      we_q     <= 1'b0;
      adr_q    <= '0;
      bs_q     <= '0;
      wdat_q   <= '0;
      a_rdat_q <= '0;
      b_rdat_q <= '0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      a_err_q  <= 1'b0;
      b_err_q  <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      bs_q     <= bs_d;
      wdat_q   <= wdat_d;
      a_rdat_q <= a_rdat_d;
      b_rdat_q <= b_rdat_d;
      a_ack_q  <= a_ack_d;
      b_ack_q  <= b_ack_d;
      a_err_q  <= a_err_d;
      b_err_q  <= b_err_d;
      tmo_q    <= tmo_d;
    end

  // host_cs decodes straight from state so an async reset drops it immediately
  always_comb begin
    host_cs   = state_q == ARB_ISSUE;
    host_adr  = {1'b0, adr_q};
    host_we   = we_q;
    host_bs   = bs_q;
    host_wdat = wdat_q;
    a_rdat    = a_rdat_q;
    b_rdat    = b_rdat_q;
    a_ack     = a_ack_q;
    b_ack     = b_ack_q;
    a_err     = a_err_q;
    b_err     = b_err_q;
    tmo_flag  = tmo_q;
  end
endmodule

// File: tb/tb_sdram_host_arb.sv
// tb_sdram_host_arb: directed vectors and corner sequences for sdram_host_arb
module tb_sdram_host_arb;
  localparam int TMO = 8;
  logic clk = 0, rst_n = 0;
  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0, host_ack = 0;
  logic [21:1] a_adr = '0, b_adr = '0;
  logic [1:0] a_bs = '0, b_bs = '0, host_bs;
  logic [15:0] a_wdat = '0, b_wdat = '0, a_rdat, b_rdat, host_wdat, host_rdat = '0;
  logic a_ack, a_err, b_ack, b_err, host_cs, host_we, tmo_flag;
  logic [21:0] host_adr;
  int total = 0, bad = 0;

  sdram_host_arb #(.AW(22), .TMO(TMO)) dut (
    .clk(clk), ._rst(rst_n),
    .a_req(a_req), .a_we(a_we), .a_adr(a_adr), .a_bs(a_bs), .a_wdat(a_wdat),
    .a_rdat(a_rdat), .a_ack(a_ack), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_adr(b_adr), .b_bs(b_bs), .b_wdat(b_wdat),
    .b_rdat(b_rdat), .b_ack(b_ack), .b_err(b_err),
    .host_cs(host_cs), .host_adr(host_adr), .host_we(host_we), .host_bs(host_bs),
    .host_wdat(host_wdat), .host_rdat(host_rdat), .host_ack(host_ack), .tmo_flag(tmo_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic        we;
    logic [21:1] adr;
    logic [1:0]  bs;
    logic [15:0] wdat;
    int          ack_cyc;
    logic [15:0] hrdat;
    logic [15:0] exp_rdat;
    logic        exp_err;
    logic        exp_tmo;
  } vec_t;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 0; a_req = 0; b_req = 0; host_ack = 0;
    repeat (2) tick;
    rst_n = 1;
  endtask

  task automatic run(input vec_t t);
    int n, exp_n;
    logic got;
    if (t.port) begin b_req = 1; b_we = t.we; b_adr = t.adr; b_bs = t.bs; b_wdat = t.wdat; end
    else begin a_req = 1; a_we = t.we; a_adr = t.adr; a_bs = t.bs; a_wdat = t.wdat; end
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin tick; got = host_cs; end
    chk("grant", got, 1);
    chk("host_adr", host_adr, {1'b0, t.adr});
    chk("host_we", host_we, t.we);
    chk("host_bs", host_bs, t.bs);
    chk("host_wdat", host_wdat, t.wdat);
    n = 1; host_rdat = t.hrdat; host_ack = t.ack_cyc == 1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick;
      if (!host_cs) got = 1;
      else begin n++; host_ack = n == t.ack_cyc; end
    end
    host_ack = 0;
    exp_n = (t.ack_cyc >= 1 && t.ack_cyc <= TMO) ? t.ack_cyc : TMO;
    chk("done", got, 1);
    chk("cs_cycles", n, exp_n);
    chk("own_ack", t.port ? b_ack : a_ack, 1);
    chk("other_ack", t.port ? a_ack : b_ack, 0);
    chk("err", t.port ? b_err : a_err, t.exp_err);
    chk("rdat", t.port ? b_rdat : a_rdat, t.exp_rdat);
    chk("tmo_flag", tmo_flag, t.exp_tmo);
    a_req = 0; b_req = 0;
    tick;
    chk("ack_one_cycle", t.port ? b_ack : a_ack, 0);
    chk("cs_idle", host_cs, 0);
  endtask

  vec_t v[7];
  logic [15:0] gw[2];
  logic [1:0] gb[2];
  int gaps[2], ord[6];

  initial begin
    v[0] = '{1'b0, 1'b0, 21'h000100, 2'b11, 16'h0000, 5, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0};
    v[1] = '{1'b1, 1'b0, 21'h1FFFFF, 2'b10, 16'h0000, 1, 16'h1234, 16'h1234, 1'b0, 1'b0};
    v[2] = '{1'b0, 1'b1, 21'h0AAAAA, 2'b01, 16'h5A5A, 2, 16'h7777, 16'hBEEF, 1'b0, 1'b0};
    v[3] = '{1'b1, 1'b1, 21'h155555, 2'b11, 16'hA5A5, 3, 16'h0000, 16'h1234, 1'b0, 1'b0};
    v[4] = '{1'b0, 1'b0, 21'h000042, 2'b11, 16'h0000, 8, 16'hCAFE, 16'hCAFE, 1'b0, 1'b0};
    v[5] = '{1'b1, 1'b0, 21'h000077, 2'b11, 16'h0000, 100, 16'h9999, 16'hFFFF, 1'b1, 1'b1};
    v[6] = '{1'b0, 1'b0, 21'h000001, 2'b11, 16'h0000, 1, 16'h0001, 16'h0001, 1'b0, 1'b1};

    do_reset;
    chk("rst_cs", host_cs, 0);
    chk("rst_adr", host_adr, 0);
    chk("rst_acks", {a_ack, b_ack, a_err, b_err, tmo_flag}, 0);
    chk("rst_rdat", {a_rdat, b_rdat}, 0);

    for (int k = 0; k < 7; k++) run(v[k]);

    begin
      int ng = 0, idle = 0;
      logic prev = 0;
      do_reset;
      a_we = 1; a_wdat = 16'h1111; a_bs = 2'b01; a_adr = 21'h10;
      b_we = 1; b_wdat = 16'h2222; b_bs = 2'b10; b_adr = 21'h20;
      a_req = 1; b_req = 1;
      for (int i = 0; i < 30 && ng < 2; i++) begin
        tick;
        if (host_cs && !prev) begin gw[ng] = host_wdat; gb[ng] = host_bs; gaps[ng] = idle; ng++; end
        idle = host_cs ? 0 : idle + 1;
        host_ack = host_cs;
        if (a_ack) a_req = 0;
        if (b_ack) b_req = 0;
        prev = host_cs;
      end
      host_ack = 0;
      chk("tie_grants", ng, 2);
      chk("tie_first_wdat", gw[0], 16'h1111);
      chk("tie_first_bs", gb[0], 2'b01);
      chk("tie_second_wdat", gw[1], 16'h2222);
      chk("tie_second_bs", gb[1], 2'b10);
      chk("tie_gap", gaps[1], 2);
    end

    begin
      int na = 0;
      do_reset;
      a_we = 0; b_we = 0; a_req = 1; b_req = 1;
      for (int i = 0; i < 60 && na < 6; i++) begin
        tick;
        host_ack = host_cs;
        if (a_ack && na < 6) begin ord[na] = 0; na++; end
        if (b_ack && na < 6) begin ord[na] = 1; na++; end
      end
      host_ack = 0; a_req = 0; b_req = 0;
      chk("rr_count", na, 6);
      for (int k = 0; k < 6; k++) chk($sformatf("rr_order%0d", k), ord[k], k % 2);
    end

    do_reset;
    a_we = 0; a_adr = 21'h33; a_req = 1;
    tick;
    chk("mid_cs_up", host_cs, 1);
    tick;
    a_req = 0; b_req = 1; b_we = 1; b_adr = 21'h0BEEF; b_wdat = 16'h3333;
    #2 rst_n = 0;
    #1 chk("mid_cs_async_drop", host_cs, 0);
    tick;
    tick;
    rst_n = 1;
    chk("mid_no_ack", {a_ack, b_ack}, 0);
    tick;
    chk("mid_b_grant", host_cs, 1);
    chk("mid_b_wdat", host_wdat, 16'h3333);
    chk("mid_no_a_ack", a_ack, 0);
    host_ack = 1;
    tick;
    host_ack = 0; b_req = 0;
    chk("mid_b_ack", b_ack, 1);
    chk("mid_a_ack_still0", a_ack, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
